// File: rtl/seq_check_ctrl_if.sv
// Control and status bundle between a test controller/CSR block and seq_check_ctrl.
// The master side arms/aborts windows and drives the monitored signal; the slave side reports results.
interface seq_check_ctrl_if #(
    parameter int CNT_W = 16,
    parameter int WIN_W = 8
);
    logic             start;
    logic             stop;
    logic [WIN_W-1:0] delay;
    logic [WIN_W-1:0] length;
    logic             a;
    logic             busy;
    logic             done;
    logic             fail;
    logic [CNT_W-1:0] fail_cnt;
    logic [CNT_W-1:0] pass_cnt;
    logic [WIN_W-1:0] first_fail;
    logic             first_fail_vld;
    logic             result;

    modport master (
        output start, stop, delay, length, a,
        input  busy, done, fail, fail_cnt, pass_cnt, first_fail, first_fail_vld, result
    );

    modport slave (
        input  start, stop, delay, length, a,
        output busy, done, fail, fail_cnt, pass_cnt, first_fail, first_fail_vld, result
    );
endinterface

// File: rtl/seq_check_ctrl.sv
// Check-window sequencer: after a programmable delay, samples 'a' for a programmable number of
// edges (or until stop), counting passes/failures and capturing the first failing sample index.
module seq_check_ctrl #(
    parameter int CNT_W = 16,
    parameter int WIN_W = 8
) (
    input  logic clk,
    input  logic rst_n,
    seq_check_ctrl_if.slave bus
);

    typedef enum logic [1:0] {IDLE, DELAY, CHECK} state_t;

    state_t           state, state_nx;
    logic [WIN_W-1:0] dly_cnt;
    logic [WIN_W-1:0] len_q;
    logic [WIN_W-1:0] idx;
    logic             accept;
    logic             abort;
    logic             sample;
    logic             last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (bus.start) state_nx = (bus.delay != '0) ? DELAY : CHECK;
            end
            DELAY: begin
                if (bus.stop)                     state_nx = IDLE;
                else if (dly_cnt == WIN_W'(1))    state_nx = CHECK;
            end
            CHECK: begin
                if (bus.stop || last) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // stop outranks sampling, so an abort edge never contributes a sample
    always_comb begin
        accept   = (state == IDLE) && bus.start;
        abort    = (state != IDLE) && bus.stop;
        sample   = (state == CHECK) && !bus.stop;
        last     = sample && (len_q != '0) && (idx == len_q - WIN_W'(1));
        bus.busy = (state != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dly_cnt            <= '0;
            len_q              <= '0;
            idx                <= '0;
            bus.done           <= 1'b0;
            bus.fail           <= 1'b0;
            bus.fail_cnt       <= '0;
            bus.pass_cnt       <= '0;
            bus.first_fail     <= '0;
            bus.first_fail_vld <= 1'b0;
            bus.result         <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            bus.fail <= 1'b0;
            if (accept) begin
                dly_cnt            <= bus.delay;
                len_q              <= bus.length;
                idx                <= '0;
                bus.fail_cnt       <= '0;
                bus.pass_cnt       <= '0;
                bus.first_fail     <= '0;
                bus.first_fail_vld <= 1'b0;
                bus.result         <= 1'b0;
            end else if (abort) begin
                bus.done   <= 1'b1;
                bus.result <= (bus.fail_cnt == '0);
            end else begin
                if (state == DELAY) dly_cnt <= dly_cnt - WIN_W'(1);
                if (sample) begin
                    if (bus.a) begin
                        if (bus.pass_cnt != '1) bus.pass_cnt <= bus.pass_cnt + CNT_W'(1);
                    end else begin
                        if (bus.fail_cnt != '1) bus.fail_cnt <= bus.fail_cnt + CNT_W'(1);
                        bus.fail <= 1'b1;
                        if (!bus.first_fail_vld) begin
                            bus.first_fail     <= idx;
                            bus.first_fail_vld <= 1'b1;
                        end
                    end
                    if (idx != '1) idx <= idx + WIN_W'(1);
                    // result must include the closing sample, which is not yet in fail_cnt
                    if (last) begin
                        bus.done   <= 1'b1;
                        bus.result <= (bus.fail_cnt == '0) && bus.a;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_seq_check_ctrl.sv
// Directed bench for seq_check_ctrl (CNT_W=4 so counter saturation is reachable quickly).
// Inputs change and outputs are checked 1 time unit after each rising edge.
module tb_seq_check_ctrl;

    logic clk;
    logic rst_n;
    int   n_assert;
    int   n_fail;

    seq_check_ctrl_if #(.CNT_W(4), .WIN_W(8)) bus ();

    seq_check_ctrl #(.CNT_W(4), .WIN_W(8)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic s, input logic p, input logic [7:0] d, input logic [7:0] l,
                         input logic av);
        bus.start  = s;
        bus.stop   = p;
        bus.delay  = d;
        bus.length = l;
        bus.a      = av;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"},  32'(bus.busy), 0);
        chk({tag, "_done"},  32'(bus.done), 0);
        chk({tag, "_fail"},  32'(bus.fail), 0);
        chk({tag, "_fcnt"},  32'(bus.fail_cnt), 0);
        chk({tag, "_pcnt"},  32'(bus.pass_cnt), 0);
        chk({tag, "_ff"},    32'(bus.first_fail), 0);
        chk({tag, "_ffv"},   32'(bus.first_fail_vld), 0);
        chk({tag, "_res"},   32'(bus.result), 0);
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        drive(0, 0, 8'd0, 8'd0, 0);
        tick(); tick();
        chk_all_zero("reset");
        rst_n = 1'b1;
        tick();

        // basic pass: delay 0, length 4
        drive(1, 0, 8'd0, 8'd4, 1);
        tick();
        drive(0, 0, 8'd0, 8'd0, 1);
        chk("bp_busy0", 32'(bus.busy), 1);
        chk("bp_pcnt0", 32'(bus.pass_cnt), 0);
        tick(); tick(); tick();
        chk("bp_pcnt3", 32'(bus.pass_cnt), 3);
        chk("bp_done3", 32'(bus.done), 0);
        tick();
        chk("bp_pcnt", 32'(bus.pass_cnt), 4);
        chk("bp_fcnt", 32'(bus.fail_cnt), 0);
        chk("bp_done", 32'(bus.done), 1);
        chk("bp_res",  32'(bus.result), 1);
        chk("bp_ffv",  32'(bus.first_fail_vld), 0);
        chk("bp_busy", 32'(bus.busy), 0);
        tick();
        chk("bp_done_pulse", 32'(bus.done), 0);
        chk("bp_res_hold",   32'(bus.result), 1);

        // failure capture: delay 2, length 10, a low at samples 0 and 7
        drive(1, 0, 8'd2, 8'd10, 0);
        tick();
        drive(0, 0, 8'd0, 8'd0, 0);
        chk("fc_res_clr", 32'(bus.result), 0);
        tick(); tick();
        chk("fc_delay_fcnt", 32'(bus.fail_cnt), 0);
        chk("fc_delay_fail", 32'(bus.fail), 0);
        bus.a = 1'b0;
        tick();
        chk("fc_fail_s0", 32'(bus.fail), 1);
        chk("fc_ff_s0",   32'(bus.first_fail), 0);
        chk("fc_ffv_s0",  32'(bus.first_fail_vld), 1);
        bus.a = 1'b1;
        tick();
        chk("fc_fail_s1", 32'(bus.fail), 0);
        tick(); tick(); tick(); tick(); tick();
        chk("fc_pcnt_s6", 32'(bus.pass_cnt), 6);
        bus.a = 1'b0;
        tick();
        chk("fc_fail_s7", 32'(bus.fail), 1);
        chk("fc_ff_s7",   32'(bus.first_fail), 0);
        bus.a = 1'b1;
        tick(); tick();
        chk("fc_fcnt", 32'(bus.fail_cnt), 2);
        chk("fc_pcnt", 32'(bus.pass_cnt), 8);
        chk("fc_done", 32'(bus.done), 1);
        chk("fc_res",  32'(bus.result), 0);
        chk("fc_busy", 32'(bus.busy), 0);
        tick();

        // abort: delay 1, continuous, start while busy ignored, stop on 6th CHECK edge
        drive(1, 0, 8'd1, 8'd0, 1);
        tick();
        drive(0, 0, 8'd0, 8'd0, 1);
        tick();
        chk("ab_delay_pcnt", 32'(bus.pass_cnt), 0);
        tick();
        drive(1, 0, 8'd7, 8'd3, 1);
        tick();
        drive(0, 0, 8'd0, 8'd0, 1);
        chk("ab_busy_start_pcnt", 32'(bus.pass_cnt), 2);
        tick(); tick(); tick();
        chk("ab_pcnt5", 32'(bus.pass_cnt), 5);
        chk("ab_busy5", 32'(bus.busy), 1);
        chk("ab_done5", 32'(bus.done), 0);
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        chk("ab_pcnt",  32'(bus.pass_cnt), 5);
        chk("ab_done",  32'(bus.done), 1);
        chk("ab_res",   32'(bus.result), 1);
        chk("ab_busy",  32'(bus.busy), 0);
        tick();
        chk("ab_done_pulse", 32'(bus.done), 0);
        chk("ab_pcnt_hold",  32'(bus.pass_cnt), 5);
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        chk("idle_stop_done", 32'(bus.done), 0);
        chk("idle_stop_busy", 32'(bus.busy), 0);

        // saturation: continuous, a low for 20 samples
        drive(1, 0, 8'd0, 8'd0, 0);
        tick();
        drive(0, 0, 8'd0, 8'd0, 0);
        for (int i = 0; i < 14; i++) tick();
        chk("sat_fcnt14", 32'(bus.fail_cnt), 14);
        for (int i = 0; i < 6; i++) tick();
        chk("sat_fcnt", 32'(bus.fail_cnt), 15);
        chk("sat_ff",   32'(bus.first_fail), 0);
        chk("sat_pcnt", 32'(bus.pass_cnt), 0);
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        chk("sat_stop_fail", 32'(bus.fail), 0);
        chk("sat_stop_done", 32'(bus.done), 1);
        chk("sat_stop_res",  32'(bus.result), 0);
        chk("sat_stop_fcnt", 32'(bus.fail_cnt), 15);
        tick();

        // start+stop together in IDLE (start wins), then async reset with fail_cnt=3
        drive(1, 1, 8'd0, 8'd0, 0);
        tick();
        drive(0, 0, 8'd0, 8'd0, 0);
        chk("ss_busy", 32'(bus.busy), 1);
        tick(); tick(); tick();
        chk("ar_fcnt3", 32'(bus.fail_cnt), 3);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("ar_async");
        tick();
        chk("ar_nodone", 32'(bus.done), 0);
        rst_n = 1'b1;
        tick();
        drive(1, 0, 8'd0, 8'd4, 1);
        tick();
        drive(0, 0, 8'd0, 8'd0, 1);
        tick(); tick(); tick(); tick();
        chk("ar_bp_pcnt", 32'(bus.pass_cnt), 4);
        chk("ar_bp_done", 32'(bus.done), 1);
        chk("ar_bp_res",  32'(bus.result), 1);
        tick();

        // back-to-back: window 1 fails at sample 1, window 2 started on the done cycle
        drive(1, 0, 8'd0, 8'd2, 1);
        tick();
        drive(0, 0, 8'd0, 8'd0, 1);
        tick();
        bus.a = 1'b0;
        tick();
        chk("bb1_done", 32'(bus.done), 1);
        chk("bb1_fcnt", 32'(bus.fail_cnt), 1);
        chk("bb1_ff",   32'(bus.first_fail), 1);
        chk("bb1_res",  32'(bus.result), 0);
        drive(1, 0, 8'd1, 8'd3, 1);
        tick();
        drive(0, 0, 8'd0, 8'd0, 1);
        chk("bb2_busy", 32'(bus.busy), 1);
        chk("bb2_done", 32'(bus.done), 0);
        chk("bb2_fcnt", 32'(bus.fail_cnt), 0);
        chk("bb2_ffv",  32'(bus.first_fail_vld), 0);
        tick(); tick(); tick();
        chk("bb2_done3", 32'(bus.done), 0);
        tick();
        chk("bb2_pcnt", 32'(bus.pass_cnt), 3);
        chk("bb2_done_end", 32'(bus.done), 1);
        chk("bb2_res",  32'(bus.result), 1);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_check_ctrl.md
Name: seq_check_ctrl

Overview:
Hardware sequencer for a sampled-signal check window. It is the RTL counterpart of the bench's "signal must be high on every posedge clk" concurrent check. After a programmable delay it samples a monitored signal for a programmable number of clk edges. It counts passes and failures, records the first failing sample index, and reports a pass/fail result. It sits beside the datapath under test and is started and stopped by the test controller or a CSR block.

Parameters:
CNT_W, 16, width of the pass/fail counters (counters saturate).
WIN_W, 8, width of the delay, length and sample-index fields.

Ports:
clk  in  1  sampling clock; all state updates on posedge clk.
rst_n  in  1  asynchronous active-low reset.
start  in  1  one-cycle request to arm a new window; honoured only in IDLE.
stop  in  1  abort the active window; ignored in IDLE.
delay  in  WIN_W  edges to skip before the first sample; latched on start.
length  in  WIN_W  number of samples; 0 = continuous until stop; latched on start.
a  in  1  monitored signal; expected high at every sampled edge.
busy  out  1  high in DELAY or CHECK.
done  out  1  one-cycle pulse when a window ends (length reached or stop).
fail  out  1  one-cycle pulse, one cycle after a sampled edge where a==0.
fail_cnt  out  CNT_W  failing samples in the current/last window.
pass_cnt  out  CNT_W  passing samples in the current/last window.
first_fail  out  WIN_W  0-based index of the first failing sample.
first_fail_vld  out  1  first_fail holds a valid index.
result  out  1  1 = last window had zero failures; valid from done until the next start.

Behaviour:
- Reset (async, rst_n low): state=IDLE; busy, done, fail, fail_cnt, pass_cnt, first_fail, first_fail_vld and result all 0. Reset mid-window discards the window with no done pulse.
- States: IDLE, DELAY, CHECK.
- IDLE, start=1 at edge T0:
  - latch delay and length;
  - clear fail_cnt, pass_cnt, first_fail, first_fail_vld and result;
  - next state is DELAY if delay!=0, else CHECK.
- DELAY: a down-counter loaded with delay, decremented each edge; moves to CHECK on the edge where it reaches 0. No samples are taken in DELAY.
- Sample timing: the first sample is at edge T0+delay+1; the sample at index k is at edge T0+delay+1+k.
- CHECK, each edge:
  - a==1: pass_cnt++.
  - a==0: fail_cnt++ and fail=1 in the next cycle. If first_fail_vld==0, set first_fail=k and first_fail_vld=1.
- Saturation: pass_cnt and fail_cnt stop at 2^CNT_W-1. The sample index k saturates at 2^WIN_W-1 in continuous mode.
- Window end (length!=0): after the sample with k=length-1, go to IDLE. done=1 in the following cycle; result=(fail_cnt==0 including that sample), registered together with done.
- stop in DELAY or CHECK:
  - stop has priority over sampling, so no sample is taken at that edge;
  - go to IDLE; done=1 in the next cycle; result=(fail_cnt==0);
  - counters hold their values.
- stop in IDLE: ignored.
- start while busy: ignored; the latched parameters do not change.
- start and stop together in IDLE: start wins, because stop is ignored in IDLE.
- start on the same edge that done is asserted (back-to-back): the controller is already in IDLE, so start is accepted. Counters clear at that edge; result is cleared, so it is visible for the done cycle only.
- Outputs are registered; no combinational path from a, start or stop to any output.

Test Plan:
- Basic pass: rst_n released, start with delay=0, length=4, a=1 throughout. Required: pass_cnt=4, fail_cnt=0, done pulse at T0+5, result=1, first_fail_vld=0.
- Failure capture: delay=2, length=10, a=0 only at samples 0 and 7 (edges T0+3 and T0+10). Required: fail pulses at T0+4 and T0+11, fail_cnt=2, pass_cnt=8, first_fail=0, result=0.
- Abort: length=0 (continuous), a=1, stop asserted at the 6th CHECK edge. Required: pass_cnt=5, done one cycle later, result=1, busy drops; a start during busy earlier has no effect.
- Saturation: CNT_W=4, length=0, a=0 for 20 sampled edges, then stop. Required: fail_cnt=15 and held; first_fail=0.
- Async reset mid-CHECK: rst_n pulled low between edges while fail_cnt=3. Required: all outputs 0 immediately, no done pulse; a new start after release behaves as in the basic pass scenario.
- Back-to-back: start asserted on the edge that done rises. Required: the new window is accepted, counters clear, and the second window's results are correct.
